// File: rtl/load_hazard_unit.sv
// In-order tracker of loads pending in the memory access stage; raises MAU_data_conflict on RAW or full-tracker hazards.
// Optional LOAD_HAZARD_RSP_BYPASS_EN: the entry retiring this cycle is excluded from operand hits.
module load_hazard_unit #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int REG_ADDR_W      = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic                  rs1_used,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic                  rs2_used,
    input  logic                  decode_is_load,
    input  logic                  issue_load_valid,
    input  logic [REG_ADDR_W-1:0] issue_load_rd,
    input  logic                  mem_rsp_valid,
    output logic [REG_ADDR_W-1:0] rsp_rd,
    output logic                  MAU_data_conflict,
    output logic [2:0]            pending_count,
    output logic                  track_err
);

    localparam int              PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [2:0]      MAX_CNT  = 3'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

    logic [REG_ADDR_W-1:0]      rd_q [MAX_OUTSTANDING];
    logic [REG_ADDR_W-1:0]      rd_d [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] vld_q, vld_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [2:0]                 count_q, count_d;
    logic                       err_q, err_d;

    logic pop, push_req, push, full;
    logic rs1_hit, rs2_hit, full_hit;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign pop      = mem_rsp_valid && (count_q != '0);
    assign push_req = issue_load_valid && (issue_load_rd != '0);
    assign full     = (count_q == MAX_CNT);
    assign push     = push_req && (!full || pop);

    always_comb begin
        rd_d     = rd_q;
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // When full, both pointers address the same slot: clear for the pop first so a simultaneous push wins.
        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = ptr_inc(rd_ptr_q);
        end
        if (push) begin
            rd_d[wr_ptr_q]  = issue_load_rd;
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (push && !pop)
            count_d = count_q + 3'd1;
        else if (pop && !push)
            count_d = count_q - 3'd1;
        err_d = err_q | (push_req && full && !pop) | (mem_rsp_valid && (count_q == '0));
    end

    always_comb begin
        logic live;
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
            live = vld_q[i];
`ifdef LOAD_HAZARD_RSP_BYPASS_EN
            if (pop && (PTR_W'(i) == rd_ptr_q))
                live = 1'b0;
`endif
            if (live && (rd_q[i] == rs1_addr)) rs1_hit = 1'b1;
            if (live && (rd_q[i] == rs2_addr)) rs2_hit = 1'b1;
        end
        if (issue_load_valid && (issue_load_rd == rs1_addr)) rs1_hit = 1'b1;
        if (issue_load_valid && (issue_load_rd == rs2_addr)) rs2_hit = 1'b1;
        rs1_hit  = rs1_hit && rs1_used && (rs1_addr != '0);
        rs2_hit  = rs2_hit && rs2_used && (rs2_addr != '0);
        full_hit = decode_is_load && full && !pop;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++)
                rd_q[i] <= '0;
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rd_q     <= rd_d;
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    assign rsp_rd            = pop ? rd_q[rd_ptr_q] : '0;
    assign MAU_data_conflict = rs1_hit || rs2_hit || full_hit;
    assign pending_count     = count_q;
    assign track_err         = err_q;

endmodule

// File: tb/tb_load_hazard_unit.sv
// Self-checking bench for load_hazard_unit: directed vector table, async reset mid-stall, and randomized traffic against a queue model.
module tb_load_hazard_unit;

    localparam int MAXO = 2;
`ifdef LOAD_HAZARD_RSP_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs1_addr, rs2_addr, issue_load_rd;
    logic       rs1_used, rs2_used, decode_is_load, issue_load_valid, mem_rsp_valid;
    logic [4:0] rsp_rd;
    logic       MAU_data_conflict;
    logic [2:0] pending_count;
    logic       track_err;

    int checks   = 0;
    int failures = 0;

    int q_m[$];
    bit err_m = 1'b0;

    load_hazard_unit #(.MAX_OUTSTANDING(MAXO), .REG_ADDR_W(5)) dut (
        .clk(clk), .reset(reset),
        .rs1_addr(rs1_addr), .rs1_used(rs1_used),
        .rs2_addr(rs2_addr), .rs2_used(rs2_used),
        .decode_is_load(decode_is_load),
        .issue_load_valid(issue_load_valid), .issue_load_rd(issue_load_rd),
        .mem_rsp_valid(mem_rsp_valid),
        .rsp_rd(rsp_rd), .MAU_data_conflict(MAU_data_conflict),
        .pending_count(pending_count), .track_err(track_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rs1; bit rs1u; int rs2; bit rs2u; bit dl; bit iv; int ird; bit rsp;
        bit econf; int ecnt; bit eerr; int ersp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int rs1, bit rs1u, int rs2, bit rs2u, bit dl, bit iv, int ird,
                                bit rsp, bit econf, int ecnt, bit eerr, int ersp);
        vec_t v;
        v.rs1 = rs1; v.rs1u = rs1u; v.rs2 = rs2; v.rs2u = rs2u; v.dl = dl;
        v.iv = iv; v.ird = ird; v.rsp = rsp;
        v.econf = econf; v.ecnt = ecnt; v.eerr = eerr; v.ersp = ersp;
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(int rs1, bit rs1u, int rs2, bit rs2u, bit dl, bit iv, int ird, bit rsp);
        rs1_addr = 5'(rs1); rs1_used = rs1u;
        rs2_addr = 5'(rs2); rs2_used = rs2u;
        decode_is_load = dl;
        issue_load_valid = iv; issue_load_rd = 5'(ird);
        mem_rsp_valid = rsp;
    endtask

    // Compare against the queue model from the current inputs, then advance the model as the edge would.
    task automatic model_cycle();
        int  n;
        bit  pop, hit, full_hit;
        n   = q_m.size();
        pop = mem_rsp_valid && (n > 0);
        hit = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (!(BYPASS && pop && i == 0)) begin
                if (rs1_used && rs1_addr != 0 && q_m[i] == int'(rs1_addr)) hit = 1'b1;
                if (rs2_used && rs2_addr != 0 && q_m[i] == int'(rs2_addr)) hit = 1'b1;
            end
        end
        if (issue_load_valid && rs1_used && rs1_addr != 0 && issue_load_rd == rs1_addr) hit = 1'b1;
        if (issue_load_valid && rs2_used && rs2_addr != 0 && issue_load_rd == rs2_addr) hit = 1'b1;
        full_hit = decode_is_load && (n == MAXO) && !pop;
        chk("model_conflict", int'(MAU_data_conflict), int'(hit || full_hit));
        chk("model_count", int'(pending_count), n);
        chk("model_err", int'(track_err), int'(err_m));
        if (pop) chk("model_rsp_rd", int'(rsp_rd), q_m[0]);
        if (pop) void'(q_m.pop_front());
        if (issue_load_valid && issue_load_rd != 0) begin
            if (n < MAXO || pop) q_m.push_back(int'(issue_load_rd));
            else err_m = 1'b1;
        end
        if (mem_rsp_valid && n == 0) err_m = 1'b1;
    endtask

    task automatic async_reset_check(string tag);
        reset = 1'b0;
        #1;
        chk({tag, "_count"}, int'(pending_count), 0);
        chk({tag, "_conflict"}, int'(MAU_data_conflict), 0);
        chk({tag, "_err"}, int'(track_err), 0);
        q_m.delete();
        err_m = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("reset_conflict", int'(MAU_data_conflict), 0);
        chk("reset_count", int'(pending_count), 0);
        chk("reset_err", int'(track_err), 0);
        chk("reset_rsp_rd", int'(rsp_rd), 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        //          rs1 u  rs2 u  dl iv ird rsp  conf       cnt err rsp
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0,         0, 0, -1)); // idle
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 5,  0, 0,         0, 0, -1)); // push 5
        tbl.push_back(mk(5, 1, 0, 0, 0, 0, 0,  0, 1,         1, 0, -1)); // RAW on 5
        tbl.push_back(mk(5, 1, 0, 0, 0, 0, 0,  1, !BYPASS,   1, 0,  5)); // retire 5
        tbl.push_back(mk(5, 1, 0, 0, 0, 0, 0,  0, 0,         0, 0, -1)); // cleared
        tbl.push_back(mk(0, 0, 7, 1, 0, 1, 7,  0, 1,         0, 0, -1)); // back-to-back on 7
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0,  0, 0,         1, 0, -1)); // x0 never tracked
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 0,         1, 0,  7)); // retire 7
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 3,  0, 0,         0, 0, -1)); // push 3
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 4,  0, 0,         1, 0, -1)); // push 4
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,  0, 1,         2, 0, -1)); // full hit
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 8,  1, 0,         2, 0,  3)); // push+pop when full
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 9,  1, 0,         2, 0,  4)); // wrap-around
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 10, 0, 0,         2, 0, -1)); // overflow push
        tbl.push_back(mk(8, 1, 0, 0, 0, 0, 0,  0, 1,         2, 1, -1)); // err sticky, 8 pending
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 0,         2, 1,  8));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 0,         1, 1,  9));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 0,         0, 1, -1)); // pop when empty
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0,         0, 1, -1));

        foreach (tbl[k]) begin
            drive(tbl[k].rs1, tbl[k].rs1u, tbl[k].rs2, tbl[k].rs2u, tbl[k].dl,
                  tbl[k].iv, tbl[k].ird, tbl[k].rsp);
            @(negedge clk);
            chk($sformatf("vec%0d_conflict", k), int'(MAU_data_conflict), int'(tbl[k].econf));
            chk($sformatf("vec%0d_count", k), int'(pending_count), tbl[k].ecnt);
            chk($sformatf("vec%0d_err", k), int'(track_err), int'(tbl[k].eerr));
            if (tbl[k].ersp >= 0) chk($sformatf("vec%0d_rsp_rd", k), int'(rsp_rd), tbl[k].ersp);
            model_cycle();
            @(posedge clk);
            #1;
        end

        // Duplicate rd: hit must persist until both copies retire.
        drive(0, 0, 0, 0, 0, 1, 11, 0);
        @(negedge clk); model_cycle(); @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 1, 11, 0);
        @(negedge clk); model_cycle(); @(posedge clk); #1;
        drive(11, 1, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("waw_first_retire", int'(MAU_data_conflict), 1);
        model_cycle(); @(posedge clk); #1;
        drive(11, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("waw_still_pending", int'(MAU_data_conflict), 1);
        chk("waw_count", int'(pending_count), 1);
        model_cycle(); @(posedge clk); #1;

        // Asynchronous reset in the middle of a stall.
        async_reset_check("midstall_reset");
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        for (int c = 0; c < 400; c++) begin
            if (c % 60 == 59) begin
                drive(0, 0, 0, 0, 0, 0, 0, 0);
                async_reset_check("rand_reset");
            end
            drive(int'($urandom_range(0, 6)), 1'($urandom), int'($urandom_range(0, 6)), 1'($urandom),
                  1'($urandom), ($urandom_range(0, 99) < 45), int'($urandom_range(0, 6)),
                  ($urandom_range(0, 99) < 40));
            @(negedge clk);
            model_cycle();
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
